// File: rtl/thegame_pkg.sv
// Shared constants for TheGame button controller: register word offsets and
// default sizing for the button/switch inputs.
package thegame_pkg;

  localparam int BTN_WIDTH           = 5;
  localparam int BTN_DEBOUNCE_CYCLES = 50000;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/thegame_button_ctrl_if.sv
// Avalon-MM slave bus bundle between the Nios II fabric and the button controller.
interface thegame_button_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata
  );

endinterface

// File: rtl/thegame_debounce.sv
// Single-bit synchronizer and debouncer: a change on the input is accepted only
// after it has been seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
module thegame_debounce #(
  parameter  int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/thegame_button_ctrl.sv
// Debounced button controller: sticky press capture (W1C), interrupt mask and
// registered Avalon-MM read mux with a level interrupt.
module thegame_button_ctrl
  import thegame_pkg::*;
#(
  parameter int WIDTH           = BTN_WIDTH,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  thegame_button_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    thegame_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .in_i     (in_port[i]),
      .stable_o (stable[i])
    );
  end

  assign unused_wdata = ^bus.writedata[31:WIDTH];

  always_comb begin
    wr_en     = bus.chipselect & bus.write;
    rise      = stable & ~stable_dly_q;
    irqmask_d = irqmask_q;
    w1c       = '0;
    if (wr_en && bus.address == ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == ADDR_EDGECAP) w1c = bus.writedata[WIDTH-1:0];
    // Applying the rise after the clear lets a same-cycle press survive a W1C.
    edgecap_d = (edgecap_q & ~w1c) | rise;
    irq_d     = |(edgecap_q & irqmask_q);
    case (bus.address)
      ADDR_DATA:    readdata_d = 32'(stable);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_dly_q <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_thegame_button_ctrl.sv
// Directed scoreboard bench for thegame_button_ctrl with an 8-cycle debounce window.
module tb_thegame_button_ctrl;
  import thegame_pkg::*;

  localparam int WIDTH = 5;
  localparam int DEB   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  thegame_button_ctrl_if bus_if ();

  thegame_button_ctrl #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0x%0h expected <none>", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic read_reg(input logic [1:0] a, input logic [31:0] v, input string tag);
    bus_if.address = a;
    expect_val(tag, v);
    tick(1);
    check(bus_if.readdata);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs = 1'b1);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.write      = 1'b1;
    bus_if.chipselect = cs;
    tick(1);
    bus_if.write      = 1'b0;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic check_irq(input string tag, input logic v);
    expect_val(tag, {31'b0, v});
    check({31'b0, irq});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    in_port           = '0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.writedata  = '0;

    // Reset state
    tick(2);
    check_irq("reset_irq", 1'b0);
    expect_val("reset_readdata", 32'h0);
    check(bus_if.readdata);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) read_reg(2'(a), 32'h0, $sformatf("reset_read%0d", a));

    // Register map boundaries
    bus_write(ADDR_IRQMASK, 32'h1F, 1'b0);
    read_reg(ADDR_IRQMASK, 32'h0, "cs0_write_ignored");
    bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
    read_reg(ADDR_RSVD, 32'h0, "reserved_read");
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    read_reg(ADDR_IRQMASK, 32'h1F, "irqmask_upper_zero");
    bus_write(ADDR_IRQMASK, 32'h0);

    // Bounce rejection: 5-cycle pulses never pass an 8-cycle window
    repeat (3) begin
      in_port[0] = 1'b1;
      tick(5);
      in_port[0] = 1'b0;
      tick(5);
    end
    tick(10);
    read_reg(ADDR_DATA, 32'h0, "bounce_data");
    read_reg(ADDR_EDGECAP, 32'h0, "bounce_edgecap");
    check_irq("bounce_irq", 1'b0);

    // Clean press on bit 2: DATA at first-sample edge + 10, irq 2 cycles after stable
    bus_write(ADDR_IRQMASK, 32'h4);
    bus_if.address = ADDR_DATA;
    in_port[2] = 1'b1;
    tick(1);
    tick(8);
    expect_val("press_data_early", 32'h0);
    tick(1);
    check(bus_if.readdata);
    expect_val("press_data_latency", 32'h4);
    tick(1);
    check(bus_if.readdata);
    check_irq("press_irq_early", 1'b0);
    tick(1);
    check_irq("press_irq", 1'b1);
    read_reg(ADDR_EDGECAP, 32'h4, "press_edgecap");
    bus_write(ADDR_IRQMASK, 32'h0);
    bus_write(ADDR_EDGECAP, 32'h4);
    tick(1);
    check_irq("clear_irq", 1'b0);
    read_reg(ADDR_EDGECAP, 32'h0, "clear_edgecap");

    // Masked press on bit 1, then unmask
    in_port[1] = 1'b1;
    tick(12);
    read_reg(ADDR_EDGECAP, 32'h2, "mask_edgecap");
    check_irq("mask_irq_off", 1'b0);
    bus_write(ADDR_IRQMASK, 32'h2);
    check_irq("mask_irq_pre", 1'b0);
    tick(1);
    check_irq("mask_irq_on", 1'b1);
    read_reg(ADDR_DATA, 32'h6, "mask_data");
    bus_write(ADDR_IRQMASK, 32'h0);
    bus_write(ADDR_EDGECAP, 32'h2);
    read_reg(ADDR_EDGECAP, 32'h0, "mask_clear_edgecap");

    // W1C racing a rise on bit 3: the write lands on the edge that captures the rise
    bus_write(ADDR_IRQMASK, 32'h8);
    in_port[3] = 1'b1;
    tick(1);
    tick(9);
    bus_write(ADDR_EDGECAP, 32'h8);
    read_reg(ADDR_EDGECAP, 32'h8, "race_set_wins");
    check_irq("race_irq", 1'b1);
    bus_write(ADDR_EDGECAP, 32'h8);
    check_irq("w1c_irq_hold", 1'b1);
    tick(2);
    check_irq("w1c_irq_drop", 1'b0);
    read_reg(ADDR_EDGECAP, 32'h0, "w1c_edgecap");

    // Reset while bit 4 is pending with irq high
    bus_write(ADDR_IRQMASK, 32'h10);
    in_port[4] = 1'b1;
    tick(12);
    check_irq("pre_reset_irq", 1'b1);
    read_reg(ADDR_EDGECAP, 32'h10, "pre_reset_edgecap");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_irq("post_reset_irq", 1'b0);
    expect_val("post_reset_readdata", 32'h0);
    check(bus_if.readdata);
    read_reg(ADDR_EDGECAP, 32'h0, "post_reset_edgecap");
    bus_if.address = ADDR_DATA;
    tick(8);
    expect_val("recapture_early", 32'h0);
    tick(1);
    check(bus_if.readdata);
    expect_val("recapture_data", 32'h1E);
    tick(1);
    check(bus_if.readdata);
    read_reg(ADDR_EDGECAP, 32'h1E, "recapture_edgecap");
    read_reg(ADDR_IRQMASK, 32'h0, "post_reset_irqmask");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
